lane_unstripe4: RTL and testbench

LANE_UNSTRIPE4 -- requirements
Module: lane_unstripe4

---
 rtl/lane_unstripe4.sv | 109 ++++++++++
 tb/tb_lane_unstripe4.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_unstripe4.sv
// lane_unstripe4 -- collects a four-lane word group in one cycle and
// serializes it onto a single registered output, lane0 first.
// A new group can be taken while lane3 is still on the output, so
// back-to-back groups stream at one word per cycle with no bubble.
module lane_unstripe4 #(
   parameter int WIDTH = 8
) (
   input  logic             clkf,
   input  logic             reset,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic             valid_in0,
   input  logic             valid_in1,
   input  logic             valid_in2,
   input  logic             valid_in3,
   output logic             ready,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             error_skew,
   output logic [7:0]       group_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state;
   logic [1:0]       idx;
   logic [WIDTH-1:0] hold_buf [1:3];
   logic [WIDTH-1:0] next_word;

   logic [3:0] valid_vec;
   logic       all_valid;
   logic       any_valid;
   logic       last_lane;
   logic       capture;
   logic       skew;

   assign valid_vec = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign all_valid = &valid_vec;
   assign any_valid = |valid_vec;

   // lane3 is on the output: the group finishes at the coming edge
   assign last_lane = (state == DRAIN) && (idx == 2'd3);

   // ready is combinational so a new group can overlap the final lane
   assign ready   = (state == IDLE) || last_lane;
   assign capture = ready && all_valid;
   assign skew    = ready && any_valid && !all_valid;

   // select the buffered word for the lane that follows the current one
   always_comb begin
      // NOTE: default assignment first so no path leaves next_word unassigned (no latch).
      next_word = hold_buf[3];
      case (idx)
         2'd0:    next_word = hold_buf[1];
         2'd1:    next_word = hold_buf[2];
         default: next_word = hold_buf[3];
      endcase
   end

   // capture / drain state machine with registered outputs
   always_ff @(posedge clkf or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= 2'd0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         error_skew <= 1'b0;
         group_cnt  <= 8'd0;
         // NOTE: the three-word holding buffer is plain flops, so it is reset
         // along with the rest; a larger RAM-style store would be left unreset.
         hold_buf[1] <= '0;
         hold_buf[2] <= '0;
         hold_buf[3] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register sees
         // the pre-edge values of the others, regardless of statement order.
         error_skew <= skew;

         if (last_lane) begin
            group_cnt <= group_cnt + 8'd1;
         end

         if (capture) begin
            data_out    <= in0;
            valid_out   <= 1'b1;
            hold_buf[1] <= in1;
            hold_buf[2] <= in2;
            hold_buf[3] <= in3;
            idx         <= 2'd0;
            state       <= DRAIN;
         end else if ((state == DRAIN) && (idx != 2'd3)) begin
            data_out  <= next_word;
            valid_out <= 1'b1;
            idx       <= idx + 2'd1;
         end else begin
            // group complete (or nothing to do): data_out keeps its last value
            valid_out <= 1'b0;
            idx       <= 2'd0;
            state     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_lane_unstripe4.sv
// tb_lane_unstripe4 -- randomized and directed stimulus for lane_unstripe4,
// with a queue-based reference model and a decoupled output monitor.
module tb_lane_unstripe4;

   localparam int WIDTH = 8;

   logic             clkf;
   logic             reset;
   logic [WIDTH-1:0] in0, in1, in2, in3;
   logic             valid_in0, valid_in1, valid_in2, valid_in3;
   logic             ready;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             error_skew;
   logic [7:0]       group_cnt;

   lane_unstripe4 #(.WIDTH(WIDTH)) dut (
      .clkf       (clkf),
      .reset      (reset),
      .in0        (in0),
      .in1        (in1),
      .in2        (in2),
      .in3        (in3),
      .valid_in0  (valid_in0),
      .valid_in1  (valid_in1),
      .valid_in2  (valid_in2),
      .valid_in3  (valid_in3),
      .ready      (ready),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .error_skew (error_skew),
      .group_cnt  (group_cnt)
   );

   initial clkf = 1'b0;
   always #5 clkf = ~clkf;

   // expected per-cycle view of the outputs after one clock edge
   typedef struct packed {
      logic             vout;
      logic [WIDTH-1:0] dhold;
      logic             err;
      logic [7:0]       cnt;
   } cyc_t;

   cyc_t             cyc_q[$];   // one entry per clock edge
   logic [WIDTH-1:0] word_q[$];  // words expected on data_out, in order
   logic [WIDTH-1:0] pend[$];    // words of the current group not yet shown

   logic             m_vis;
   logic [WIDTH-1:0] m_last;
   logic [7:0]       m_cnt;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // apply one cycle of inputs and advance the reference model by one edge
   task automatic drive_cycle(input logic [3:0] v, input logic [WIDTH-1:0] d0,
                              input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                              input logic [WIDTH-1:0] d3);
      logic m_ready;
      logic [WIDTH-1:0] w;
      @(negedge clkf);
      m_ready = (pend.size() == 0);
      check("ready", ready, m_ready);
      {valid_in3, valid_in2, valid_in1, valid_in0} = v;
      in0 = d0; in1 = d1; in2 = d2; in3 = d3;
      // a group is finished when its last word is showing and nothing remains
      if (m_vis && pend.size() == 0) m_cnt = m_cnt + 8'd1;
      if (m_ready && (v == 4'hF)) begin
         word_q.push_back(d0);
         pend.delete();
         pend.push_back(d1);
         pend.push_back(d2);
         pend.push_back(d3);
         m_vis  = 1'b1;
         m_last = d0;
      end else if (pend.size() > 0) begin
         w = pend.pop_front();
         word_q.push_back(w);
         m_vis  = 1'b1;
         m_last = w;
      end else begin
         m_vis = 1'b0;
      end
      cyc_q.push_back('{vout: m_vis, dhold: m_last,
                        err: m_ready && (v != 4'h0) && (v != 4'hF), cnt: m_cnt});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   // assert reset now, verify the reset state at once, release after an edge
   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_ready", ready, 1'b1);
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid_out", valid_out, 1'b0);
      check("rst_error_skew", error_skew, 1'b0);
      check("rst_group_cnt", group_cnt, 8'd0);
      pend.delete();
      word_q.delete();
      cyc_q.delete();
      m_vis  = 1'b0;
      m_last = '0;
      m_cnt  = 8'd0;
      {valid_in3, valid_in2, valid_in1, valid_in0} = 4'h0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      @(posedge clkf);
      #2 reset = 1'b1;
   endtask

   // monitor: compares each clock edge's outputs against the model
   initial begin
      cyc_t e;
      forever begin
         @(posedge clkf);
         #1;
         if (reset === 1'b1 && cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            check("valid_out", valid_out, e.vout);
            check("error_skew", error_skew, e.err);
            check("group_cnt", group_cnt, e.cnt);
            if (valid_out === 1'b1) begin
               if (word_q.size() == 0) begin
                  check("unexpected_word", data_out, 32'hFFFF_FFFF);
               end else begin
                  check("data_out", data_out, word_q.pop_front());
               end
            end else begin
               check("data_hold", data_out, e.dhold);
            end
         end
      end
   end

   // stimulus
   initial begin
      int captured;
      logic [3:0] v;
      reset = 1'b0;
      {valid_in3, valid_in2, valid_in1, valid_in0} = 4'h0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      m_vis = 1'b0; m_last = '0; m_cnt = 8'd0;
      #1;
      do_reset();

      // single group
      drive_cycle(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
      idle(6);
      check("single_cnt", group_cnt, 8'd1);

      // back-to-back groups with valids held high whenever ready
      #2 do_reset();
      captured = 0;
      while (captured < 2) begin
         if (pend.size() == 0) begin
            if (captured == 0) drive_cycle(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
            else               drive_cycle(4'hF, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
            captured++;
         end else begin
            drive_cycle(4'hF, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         end
      end
      idle(6);
      check("b2b_cnt", group_cnt, 8'd2);

      // skew while idle, then a normal group
      #2 do_reset();
      drive_cycle(4'b1011, 8'h01, 8'h02, 8'h03, 8'h04);
      drive_cycle(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
      idle(5);

      // busy: random valids and data while not ready are ignored
      drive_cycle(4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
      for (int i = 0; i < 3; i++)
         drive_cycle(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      // skew exactly on the last lane: no capture, error, return to idle
      drive_cycle(4'b0110, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
      idle(4);

      // async reset between edges after lane1 is shown
      #2 do_reset();
      drive_cycle(4'hF, 8'h91, 8'h92, 8'h93, 8'h94);
      drive_cycle(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clkf);
      #2;
      check("pre_abort_data", data_out, 8'h92);
      do_reset();
      drive_cycle(4'hF, 8'h55, 8'h66, 8'h77, 8'h88);
      idle(6);
      check("after_abort_cnt", group_cnt, 8'd1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    v = 4'hF;
            2:       v = 4'h0;
            default: v = 4'($urandom);
         endcase
         drive_cycle(v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle(6);

      // group counter wrap
      #2 do_reset();
      captured = 0;
      while (captured < 255) begin
         if (pend.size() == 0) begin
            drive_cycle(4'hF, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            captured++;
         end else begin
            drive_cycle(4'h0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         end
      end
      idle(6);
      check("cnt_255", group_cnt, 8'd255);
      drive_cycle(4'hF, 8'h5A, 8'hA5, 8'h3C, 8'hC3);
      idle(6);
      check("cnt_wrap", group_cnt, 8'd0);

      @(posedge clkf);
      #2;
      check("words_left", word_q.size(), 0);
      check("cycles_left", cyc_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
